// File: rtl/pixram_dbuf.sv
// pixram_dbuf: double-buffered framebuffer, lane writes to the back page, full-word reads from the front page,
// page swap deferred to a frame boundary via a request/acknowledge handshake.
module pixram_dbuf #(
  parameter int ADDR_WIDTH = 12,
  parameter int LANES = 4,
  parameter int LANE_WIDTH = 8,
  localparam int LB = $clog2(LANES),
  localparam int WADDR_WIDTH = ADDR_WIDTH + LB
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [WADDR_WIDTH-1:0]      wr_addr,
  input  logic [LANE_WIDTH-1:0]       wr_data,
  input  logic                        rd_en,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [LANES*LANE_WIDTH-1:0] rd_data,
  output logic                        rd_valid,
  input  logic                        swap_req,
  input  logic                        frame_end,
  output logic                        swap_pending,
  output logic                        swap_ack,
  output logic                        front_page
);
  localparam int DEPTH = 2 * LANES * (2 ** ADDR_WIDTH);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t r_state, w_state_nx;
  logic w_swap;
  logic r_front;
  // flat storage indexed {page, lane, word}; a lane write address is already {lane, word}
  logic [LANE_WIDTH-1:0] r_mem [DEPTH];
  assign front_page = r_front;
  always_comb begin
    w_swap = frame_end && (r_state == PENDING || swap_req);
    w_state_nx = w_swap ? IDLE : (swap_req ? PENDING : r_state);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      swap_pending <= 1'b0;
      swap_ack <= 1'b0;
      r_front <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      r_state <= w_state_nx;
      swap_pending <= w_state_nx == PENDING;
      swap_ack <= w_swap;
      r_front <= r_front ^ w_swap;
      rd_valid <= rd_en;
      if (rd_en)
        for (int k = 0; k < LANES; k++)
          rd_data[(LANES-k)*LANE_WIDTH-1 -: LANE_WIDTH] <= r_mem[{r_front, LB'(k), rd_addr}];
    end
  end
  // reads and writes use the pre-swap page, so they never collide
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[{~r_front, wr_addr}] <= wr_data;
  end
endmodule

// File: tb/tb_pixram_dbuf.sv
// tb_pixram_dbuf: scoreboard-driven checks of lane mapping, paging, swap handshake and reset.
module tb_pixram_dbuf;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, wr_en, rd_en, swap_req, frame_end;
  logic [13:0] wr_addr;
  logic [7:0] wr_data;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic rd_valid, swap_pending, swap_ack, front_page;
  logic p_rst_n, p_wr_en, p_rd_en, p_swap_req, p_frame_end;
  logic [4:0] p_wr_addr;
  logic [15:0] p_wr_data;
  logic [3:0] p_rd_addr;
  logic [31:0] p_rd_data;
  logic p_rd_valid, p_swap_pending, p_swap_ack, p_front_page;
  logic [31:0] q[$];
  logic [31:0] exp_v;
  int checks = 0;
  int errors = 0;

  pixram_dbuf dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .swap_req(swap_req), .frame_end(frame_end), .swap_pending(swap_pending),
    .swap_ack(swap_ack), .front_page(front_page)
  );

  pixram_dbuf #(.ADDR_WIDTH(4), .LANES(2), .LANE_WIDTH(16)) dut_p (
    .clk(clk), .rst_n(p_rst_n), .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
    .rd_en(p_rd_en), .rd_addr(p_rd_addr), .rd_data(p_rd_data), .rd_valid(p_rd_valid),
    .swap_req(p_swap_req), .frame_end(p_frame_end), .swap_pending(p_swap_pending),
    .swap_ack(p_swap_ack), .front_page(p_front_page)
  );

  task tick;
    @(posedge clk);
    #1;
  endtask

  task wr(input logic [1:0] l, input logic [11:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = {l, a};
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task test_reset;
    rst_n = 1'b0; p_rst_n = 1'b0; rd_en = 1'b1;
    tick();
    tick();
    checks++; if (front_page !== 1'b0) begin errors++; $display("FAIL reset_front got %b want 0", front_page); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", swap_pending); end
    checks++; if (swap_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", swap_ack); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    rst_n = 1'b1; p_rst_n = 1'b1; rd_en = 1'b0;
    tick();
  endtask

  task test_lane_map;
    wr(2'd0, 12'h005, 8'h11);
    wr(2'd1, 12'h005, 8'h22);
    wr(2'd2, 12'h005, 8'h33);
    wr(2'd3, 12'h005, 8'h44);
    swap_req = 1'b1; frame_end = 1'b1;
    tick();
    swap_req = 1'b0; frame_end = 1'b0;
    checks++; if (front_page !== 1'b1) begin errors++; $display("FAIL lane_swap_front got %b want 1", front_page); end
    checks++; if (swap_ack !== 1'b1) begin errors++; $display("FAIL lane_swap_ack got %b want 1", swap_ack); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL lane_swap_pending got %b want 0", swap_pending); end
    rd_en = 1'b1; rd_addr = 12'd5; q.push_back(32'h11223344);
    tick();
    rd_en = 1'b0;
    exp_v = q.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp_v) begin errors++; $display("FAIL lane_map got v=%b %h want v=1 %h", rd_valid, rd_data, exp_v); end
    tick();
    checks++; if (rd_valid !== 1'b0 || rd_data !== exp_v) begin errors++; $display("FAIL rd_hold got v=%b %h want v=0 %h", rd_valid, rd_data, exp_v); end
  endtask

  task test_isolation;
    wr(2'd0, 12'h005, 8'hAA);
    rd_en = 1'b1; rd_addr = 12'd5; q.push_back(32'h11223344);
    tick();
    rd_en = 1'b0;
    exp_v = q.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp_v) begin errors++; $display("FAIL isolation got v=%b %h want %h", rd_valid, rd_data, exp_v); end
  endtask

  task test_deferred;
    wr(2'd1, 12'h005, 8'hB1);
    wr(2'd2, 12'h005, 8'hB2);
    wr(2'd3, 12'h005, 8'hB3);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    checks++; if (swap_pending !== 1'b1 || swap_ack !== 1'b0 || front_page !== 1'b1) begin errors++; $display("FAIL defer_req got p=%b a=%b f=%b want 1 0 1", swap_pending, swap_ack, front_page); end
    tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    checks++; if (swap_pending !== 1'b1 || front_page !== 1'b1) begin errors++; $display("FAIL defer_hold got p=%b f=%b want 1 1", swap_pending, front_page); end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    checks++; if (front_page !== 1'b0 || swap_ack !== 1'b1 || swap_pending !== 1'b0) begin errors++; $display("FAIL defer_exec got f=%b a=%b p=%b want 0 1 0", front_page, swap_ack, swap_pending); end
    for (int i = 0; i < 3; i++) begin
      frame_end = (i == 1);
      tick();
      checks++; if (swap_ack !== 1'b0 || front_page !== 1'b0) begin errors++; $display("FAIL defer_single_ack got a=%b f=%b want 0 0", swap_ack, front_page); end
    end
    frame_end = 1'b0;
    rd_en = 1'b1; rd_addr = 12'd5; q.push_back(32'hAAB1B2B3);
    tick();
    rd_en = 1'b0;
    exp_v = q.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp_v) begin errors++; $display("FAIL defer_read got v=%b %h want %h", rd_valid, rd_data, exp_v); end
  endtask

  task test_boundary;
    wr(2'd1, 12'h007, 8'h61);
    wr(2'd2, 12'h007, 8'h62);
    wr(2'd3, 12'h007, 8'h63);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    frame_end = 1'b1;
    rd_en = 1'b1; rd_addr = 12'd5; q.push_back(32'hAAB1B2B3);
    wr_en = 1'b1; wr_addr = {2'd0, 12'h007}; wr_data = 8'h5A;
    tick();
    frame_end = 1'b0; wr_en = 1'b0;
    exp_v = q.pop_front();
    checks++; if (front_page !== 1'b1 || swap_ack !== 1'b1) begin errors++; $display("FAIL boundary_swap got f=%b a=%b want 1 1", front_page, swap_ack); end
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp_v) begin errors++; $display("FAIL boundary_old_read got v=%b %h want %h", rd_valid, rd_data, exp_v); end
    rd_addr = 12'd7; q.push_back(32'h5A616263);
    tick();
    rd_en = 1'b0;
    exp_v = q.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp_v) begin errors++; $display("FAIL boundary_old_back_write got v=%b %h want %h", rd_valid, rd_data, exp_v); end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    checks++; if (front_page !== 1'b1 || swap_ack !== 1'b0 || swap_pending !== 1'b0) begin errors++; $display("FAIL lone_frame_end got f=%b a=%b p=%b want 1 0 0", front_page, swap_ack, swap_pending); end
  endtask

  task test_back_to_back;
    rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rd_addr = i[0] ? 12'd7 : 12'd5;
      q.push_back(i[0] ? 32'h5A616263 : 32'h11223344);
      wr_en = 1'b1; wr_addr = {i[1:0], 12'h009}; wr_data = 8'(i);
      tick();
      exp_v = q.pop_front();
      checks++; if (rd_valid !== 1'b1 || rd_data !== exp_v) begin errors++; $display("FAIL b2b_read_%0d got v=%b %h want %h", i, rd_valid, rd_data, exp_v); end
    end
    rd_en = 1'b0; wr_en = 1'b0;
    tick();
  endtask

  task test_reset_mid;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    checks++; if (swap_pending !== 1'b1 || front_page !== 1'b1) begin errors++; $display("FAIL mid_pre got p=%b f=%b want 1 1", swap_pending, front_page); end
    rst_n = 1'b0; rd_en = 1'b1; rd_addr = 12'd5;
    tick();
    rst_n = 1'b1; rd_en = 1'b0;
    checks++; if (front_page !== 1'b0 || swap_pending !== 1'b0) begin errors++; $display("FAIL mid_reset got f=%b p=%b want 0 0", front_page, swap_pending); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin errors++; $display("FAIL mid_reset_rd got v=%b %h want 0 0", rd_valid, rd_data); end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    checks++; if (front_page !== 1'b0 || swap_ack !== 1'b0) begin errors++; $display("FAIL mid_discard got f=%b a=%b want 0 0", front_page, swap_ack); end
  endtask

  task test_param;
    p_wr_en = 1'b1; p_wr_addr = 5'h0F; p_wr_data = 16'hBEEF;
    tick();
    p_wr_addr = 5'h1F; p_wr_data = 16'hCAFE;
    tick();
    p_wr_en = 1'b0; p_swap_req = 1'b1; p_frame_end = 1'b1;
    tick();
    p_swap_req = 1'b0; p_frame_end = 1'b0;
    checks++; if (p_front_page !== 1'b1 || p_swap_ack !== 1'b1) begin errors++; $display("FAIL param_swap got f=%b a=%b want 1 1", p_front_page, p_swap_ack); end
    p_rd_en = 1'b1; p_rd_addr = 4'hF; q.push_back(32'hBEEFCAFE);
    tick();
    p_rd_en = 1'b0;
    exp_v = q.pop_front();
    checks++; if (p_rd_valid !== 1'b1 || p_rd_data !== exp_v) begin errors++; $display("FAIL param_read got v=%b %h want %h", p_rd_valid, p_rd_data, exp_v); end
  endtask

  initial begin
    wr_en = 0; rd_en = 0; swap_req = 0; frame_end = 0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    p_wr_en = 0; p_rd_en = 0; p_swap_req = 0; p_frame_end = 0; p_wr_addr = '0; p_wr_data = '0; p_rd_addr = '0;
    test_reset();
    test_lane_map();
    test_isolation();
    test_deferred();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    test_param();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
